// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns core load/store requests into single-port
// RAM cycles, doing read-modify-write for sub-word stores and lane extraction for loads.
module dmem_ctrl #(
  parameter int ADDRESS_SIZE = 12,
  parameter int N            = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_word_control,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [N-1:0]            req_wdata,
  output logic                    rsp_valid,
  output logic [N-1:0]            rsp_rdata,
  output logic                    rsp_error,
  output logic [ADDRESS_SIZE-3:0] mem_addr,
  output logic                    mem_we,
  output logic [N-1:0]            mem_wdata,
  input  logic [N-1:0]            mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]              state_reg, state_next;
  logic                    ready_reg;
  logic                    write_reg;
  logic [2:0]              wc_reg;
  logic [ADDRESS_SIZE-1:0] addr_reg;
  logic [N-1:0]            word_reg;
  logic [N-1:0]            rdata_reg;
  logic                    err_reg;

  logic                    accept;
  logic                    req_err;
  logic                    req_store_word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [N-1:0]            load_val;
  logic [N-1:0]            merged;

  assign accept = req_valid && ready_reg;

  always_comb begin
    req_err = 1'b0;
    case (req_word_control)
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      default:        req_err = 1'b0;
    endcase
    if (req_write && req_word_control[2])
      req_err = 1'b1;
  end

  assign req_store_word = req_write && (req_word_control == 3'b010);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = req_err ? RESP : (req_store_word ? WR : RD);
      RD:   state_next = DATA;
      DATA: state_next = write_reg ? WR : RESP;
      WR:   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane selection uses the latched address; mem_rdata is valid during DATA.
  assign byte_sel = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (wc_reg[1:0])
      2'b00:   load_val = {{(N-8){byte_sel[7] & ~wc_reg[2]}}, byte_sel};
      2'b01:   load_val = {{(N-16){half_sel[15] & ~wc_reg[2]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (wc_reg[1:0] == 2'b00)
      merged[{addr_reg[1:0], 3'b000} +: 8] = word_reg[7:0];
    else
      merged[{addr_reg[1], 4'b0000} +: 16] = word_reg[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
      write_reg <= 1'b0;
      wc_reg    <= '0;
      addr_reg  <= '0;
      word_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == IDLE);
      if (accept) begin
        write_reg <= req_write;
        wc_reg    <= req_word_control;
        addr_reg  <= req_addr;
        word_reg  <= req_wdata;
        rdata_reg <= '0;
        err_reg   <= req_err;
      end
      // word_reg carries the store data until DATA replaces it with the merged word
      if (state_reg == DATA) begin
        if (write_reg)
          word_reg <= merged;
        else
          rdata_reg <= load_val;
      end
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_error = rsp_valid && err_reg;
  assign rsp_rdata = rdata_reg;
  assign mem_addr  = addr_reg[ADDRESS_SIZE-1:2];
  assign mem_we    = (state_reg == WR);
  assign mem_wdata = mem_we ? word_reg : '0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 12, which is the byte-address width.
REQ-002 The block SHALL have parameter N, default 32, which is the data width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit, indicating the core presents an access.
REQ-006 The block SHALL have port req_ready, output, 1 bit, indicating the controller can accept an access.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_word_control, input, 3 bits: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 The block SHALL have port req_addr, input, ADDRESS_SIZE bits, the byte address.
REQ-010 The block SHALL have port req_wdata, input, N bits, the store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, N bits, the extended load result.
REQ-013 The block SHALL have port rsp_error, output, 1 bit, flagging an access that was rejected without a memory operation.
REQ-014 The block SHALL have port mem_addr, output, ADDRESS_SIZE-2 bits, the word index to the RAM.
REQ-015 The block SHALL have port mem_we, output, 1 bit, the RAM write enable.
REQ-016 The block SHALL have port mem_wdata, output, N bits, the RAM write word.
REQ-017 The block SHALL have port mem_rdata, input, N bits, the RAM read word; it is valid the cycle after mem_addr is presented.

Function
REQ-018 The controller SHALL use an FSM with states IDLE, RD, DATA, WR and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; an access is accepted on a clock edge where req_valid and req_ready are both 1, and all request fields SHALL be latched at that edge.
REQ-020 An accepted access SHALL be an error if it is a half access with addr[0]=1, a word access with addr[1:0]≠00, req_word_control is 011, 110 or 111, or it is a store with req_word_control[2]=1.
REQ-021 From IDLE, acceptance SHALL move the FSM to RESP on error, to WR for a word store, and to RD otherwise.
REQ-022 RD SHALL drive mem_addr = latched addr[ADDRESS_SIZE-1:2] with mem_we=0, then go to DATA.
REQ-023 For a load in DATA, the FSM SHALL register the selected lane of mem_rdata, sign-extended (000/001) or zero-extended (100/101) from byte addr[1:0] or half addr[1], then go to RESP.
REQ-024 For a sub-word store in DATA, the FSM SHALL register mem_rdata with only the addressed byte or half replaced by req_wdata[7:0] or [15:0], then go to WR.
REQ-025 WR SHALL assert mem_we=1 for exactly one cycle, with mem_wdata set to the merged word (sub-word store) or latched wdata (word store), then go to RESP.
REQ-026 RESP SHALL assert rsp_valid=1 for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-027 rsp_rdata SHALL carry the load result; it SHALL be 0 for stores and errors.
REQ-028 rsp_error SHALL be meaningful only while rsp_valid=1.
REQ-029 Latency from the accept edge to rsp_valid SHALL be: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-030 mem_we SHALL be 0 in every state except WR; an errored access SHALL never assert mem_we.
REQ-031 mem_addr SHALL hold the latched word index outside RD and WR.
REQ-032 A new access SHALL NOT be accepted earlier than the cycle after RESP; req_valid held high while the controller is busy SHALL wait without loss.

Reset
REQ-033 While rst=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, except req_ready, which SHALL be 0 during reset and 1 in the first cycle after release.
REQ-034 Reset asserted mid-access SHALL abort the access with no mem_we, no rsp_valid, and the latched request discarded.

Verification
REQ-035 Preload word 5 = 0x80FF7F01; LB at addr 0x017 -> rsp_valid 3 cycles after accept with rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 With the same preload, SB at 0x016 with wdata 0x000000AB -> mem_we=1 with mem_addr=5 and mem_wdata=0x80AB7F01 at accept+3; rsp_valid at accept+4 with rsp_error=0.
REQ-037 SW at 0x010 with wdata 0xDEADBEEF -> mem_we=1 with mem_addr=4 and mem_wdata=0xDEADBEEF at accept+1; rsp_valid at accept+2.
REQ-038 LH at 0x013 -> rsp_valid at accept+1 with rsp_error=1 and rsp_rdata=0, and mem_we stays 0; SBU (store with 100) -> same error response.
REQ-039 rst pulled low during DATA of an SH -> no mem_we pulse and no rsp_valid; after release, req_ready=1 and an LW to 0x014 returns 0x80FF7F01.
REQ-040 req_valid held high for two back-to-back LWs -> req_ready=0 from accept until after RESP; the second access is accepted in the cycle after the first rsp_valid and both responses are correct.
